cal_accum_requant_int8: RTL and testbench

- Consumer end of the int18 adder-tree datapath. Takes one signed 18-bit partial sum per accepted beat, for one output pixel/channel at a time.
- Accumulates the partial sums over a configurable number of input-channel groups, then requantizes the total. Requantization is a rounding arithmetic right shift, an activation, and saturation to int8.
- Presents the int8 result on a valid/ready stream to the feature-map write-back path.

---
 rtl/cal_quant_pkg.sv | 20 ++
 rtl/cal_round_sat_int8.sv | 53 +++++
 rtl/cal_accum_requant_int8.sv | 108 ++++++++++
 tb/tb_cal_accum_requant_int8.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cal_quant_pkg.sv
// Shared widths, requantization constants and typedefs for the int18 accumulate/requant block.
// The leaky activation is selected at build time with CAL_ACT_LEAKY_EN.
package cal_quant_pkg;

    localparam int CAL_PSUM_W = 18;
    localparam int CAL_ACC_W  = 32;
    localparam int CAL_OUT_W  = 8;

    localparam int LEAKY_MUL = 13;
    localparam int LEAKY_SHR = 7;
    localparam int LEAKY_RND = 64;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    typedef logic signed [CAL_PSUM_W-1:0] psum_t;
    typedef logic signed [CAL_ACC_W-1:0]  acc_t;
    typedef logic signed [CAL_OUT_W-1:0]  q8_t;

endpackage

// File: rtl/cal_round_sat_int8.sv
// Combinational requant helpers: rounding arithmetic shift, then activation and int8 clamp.
// Leaky activation on negative values when CAL_ACT_LEAKY_EN is defined, linear otherwise.
module cal_round_sat_int8
    import cal_quant_pkg::*;
#(
    parameter int ACC_W = CAL_ACC_W,
    parameter int OUT_W = CAL_OUT_W
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [4:0]       shift,
    output logic signed [ACC_W-1:0] r,
    input  logic signed [ACC_W-1:0] r_in,
    output logic signed [OUT_W-1:0] q
);

    localparam int AW = ACC_W + 8;

    logic signed [ACC_W:0] acc_w;
    logic signed [ACC_W:0] half;
    logic signed [ACC_W:0] sum;
    logic signed [AW-1:0]  r_w;
    logic signed [AW-1:0]  act;

    // One extra bit so adding the rounding half can never wrap.
    always_comb begin
        acc_w = {acc[ACC_W-1], acc};
        half  = (ACC_W+1)'(1) << (shift - 5'd1);
        sum   = acc_w + half;
        if (shift == 5'd0)
            r = acc;
        else
            r = ACC_W'(sum >>> shift);
    end

    always_comb begin
        r_w = AW'(r_in);
`ifdef CAL_ACT_LEAKY_EN
        if (r_w < 0)
            act = (r_w * AW'(LEAKY_MUL) + AW'(LEAKY_RND)) >>> LEAKY_SHR;
        else
            act = r_w;
`else
        act = r_w;
`endif
        if (act > AW'(INT8_MAX))
            q = OUT_W'(INT8_MAX);
        else if (act < AW'(INT8_MIN))
            q = OUT_W'(INT8_MIN);
        else
            q = OUT_W'(act);
    end

endmodule

// File: rtl/cal_accum_requant_int8.sv
// Accumulates signed partial sums over cfg_groups beats, then requantizes to int8 through
// a 3-stage stallable pipeline (S1 round/shift, S2 activate/clamp, output register).
module cal_accum_requant_int8
    import cal_quant_pkg::*;
#(
    parameter int PSUM_W = CAL_PSUM_W,
    parameter int ACC_W  = CAL_ACC_W,
    parameter int OUT_W  = CAL_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic        [7:0]        cfg_groups,
    input  logic        [4:0]        cfg_shift,
    input  logic                     psum_valid,
    input  logic signed [PSUM_W-1:0] psum,
    output logic                     psum_ready,
    output logic                     dout_valid,
    output logic signed [OUT_W-1:0]  dout,
    input  logic                     dout_ready
);

    logic        [7:0]       grp_cnt;
    logic        [7:0]       last;
    logic        [7:0]       cfg_last;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] psum_ext;
    logic                    is_final;
    logic                    accept;

    logic                    s1_v;
    logic signed [ACC_W-1:0] s1_acc;
    logic        [4:0]       s1_shift;
    logic                    s2_v;
    logic signed [ACC_W-1:0] s2_r;

    logic signed [ACC_W-1:0] r_comb;
    logic signed [OUT_W-1:0] q_comb;
    logic                    out_adv;
    logic                    s1_adv;

    // At the start of a group the limit comes straight from cfg_groups, since it is not latched yet.
    always_comb begin
        cfg_last = (cfg_groups == 8'd0) ? 8'd0 : cfg_groups - 8'd1;
        is_final = (grp_cnt == 8'd0) ? (cfg_last == 8'd0) : (grp_cnt == last);
        psum_ext = ACC_W'(psum);
        acc_next = (grp_cnt == 8'd0) ? psum_ext : acc + psum_ext;
        out_adv  = !dout_valid || dout_ready;
        s1_adv   = !s2_v || out_adv;
        psum_ready = !(is_final && s1_v && !s1_adv);
        accept   = psum_valid && psum_ready;
    end

    cal_round_sat_int8 #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .acc   (s1_acc),
        .shift (s1_shift),
        .r     (r_comb),
        .r_in  (s2_r),
        .q     (q_comb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_cnt <= '0;
            last    <= '0;
            acc     <= '0;
        end else if (accept) begin
            acc <= acc_next;
            if (grp_cnt == 8'd0)
                last <= cfg_last;
            grp_cnt <= is_final ? 8'd0 : grp_cnt + 8'd1;
        end
    end

    // A final psum may overwrite S1 in the same cycle S1 hands its data on to S2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_acc   <= '0;
            s1_shift <= '0;
            s2_v     <= 1'b0;
            s2_r     <= '0;
            dout_valid <= 1'b0;
            dout       <= '0;
        end else begin
            if (accept && is_final) begin
                s1_v     <= 1'b1;
                s1_acc   <= acc_next;
                s1_shift <= cfg_shift;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end
            if (s1_adv) begin
                s2_v <= s1_v;
                s2_r <= r_comb;
            end
            if (out_adv) begin
                dout_valid <= s2_v;
                if (s2_v)
                    dout <= q_comb;
            end
        end
    end

endmodule

// File: tb/tb_cal_accum_requant_int8.sv
// Scoreboard bench for cal_accum_requant_int8: directed cases plus randomized traffic
// checked against an arithmetic reference model; honours CAL_ACT_LEAKY_EN like the RTL.
module tb_cal_accum_requant_int8;
    import cal_quant_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        cfg_groups = 8'd1;
    logic [4:0]        cfg_shift = 5'd0;
    logic              psum_valid = 1'b0;
    logic signed [17:0] psum = '0;
    logic              psum_ready;
    logic              dout_valid;
    logic signed [7:0] dout;
    logic              dout_ready;

    int  ready_mode = 0;
    logic rnd_bit = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    q8_t    exp_q[$];
    int     m_cnt = 0;
    int     m_last = 0;
    longint m_acc = 0;

    cal_accum_requant_int8 dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_groups (cfg_groups),
        .cfg_shift  (cfg_shift),
        .psum_valid (psum_valid),
        .psum       (psum),
        .psum_ready (psum_ready),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    assign dout_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : rnd_bit;

    initial forever begin
        @(negedge clk);
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // Reference: floor((acc + 2^(s-1)) / 2^s), optional leaky scaling, clamp to int8.
    function automatic q8_t ref_q(input longint a, input int s);
        longint r;
        longint v;
        if (s == 0) r = a;
        else r = (a + (longint'(1) << (s - 1))) >>> s;
        v = r;
`ifdef CAL_ACT_LEAKY_EN
        if (r < 0) v = (r * 13 + 64) >>> 7;
`endif
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return q8_t'(v);
    endfunction

    task automatic check_output(input string name, input logic signed [31:0] act,
                                input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input int p, input int g, input int s);
        if (m_cnt == 0) begin
            m_last = (g == 0) ? 0 : g - 1;
            m_acc = p;
        end else begin
            m_acc += p;
        end
        if (m_cnt == m_last) begin
            exp_q.push_back(ref_q(m_acc, s));
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the beat was taken.
    task automatic apply_stimulus(input int p, input int g, input int s);
        int waited = 0;
        psum_valid = 1'b1;
        psum = 18'(p);
        cfg_groups = 8'(g);
        cfg_shift = 5'(s);
        #1;
        while (!psum_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!psum_ready) begin
            check_output("psum_ready_timeout", 32'(psum_ready), 32'sd1);
        end else begin
            model_accept(p, g, s);
            @(posedge clk);
        end
        @(negedge clk);
        psum_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        m_cnt = 0;
        m_acc = 0;
        #1;
        check_output("rst_psum_ready", 32'(psum_ready), 32'sd1);
        check_output("rst_dout_valid", 32'(dout_valid), 32'sd0);
        check_output("rst_dout", 32'(dout), 32'sd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain();
        int cnt = 0;
        ready_mode = 0;
        while (exp_q.size() != 0 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        check_output("drain", 32'(exp_q.size()), 32'sd0);
        repeat (6) @(negedge clk);
    endtask

    // Monitor: every output handshake must match the oldest expected result.
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_dout", 32'(dout), 32'sd9999);
            end else begin
                q8_t e;
                e = exp_q.pop_front();
                check_output("dout", 32'(dout), 32'(e));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        do_reset();
        @(negedge clk);

        // Two-group sum with shift 4, including the 3-cycle latency.
        apply_stimulus(100, 2, 4);
        apply_stimulus(60, 2, 4);
        #1;
        check_output("lat_e0", 32'(dout_valid), 32'sd0);
        @(negedge clk); #1;
        check_output("lat_e1", 32'(dout_valid), 32'sd0);
        @(negedge clk); #1;
        check_output("lat_e2", 32'(dout_valid), 32'sd1);
        @(negedge clk);

        apply_stimulus(-50, 1, 0);
        apply_stimulus(5000, 1, 0);
        apply_stimulus(-5000, 1, 0);
        apply_stimulus(0, 0, 1);
        apply_stimulus(3, 0, 1);
        apply_stimulus(5, 1, 31);
        apply_stimulus(-5, 1, 31);
        apply_stimulus(-131072, 1, 31);
        wait_drain();

        // Backpressure: three results fill the pipe, the fourth final psum must stall.
        ready_mode = 1;
        apply_stimulus(10, 1, 0);
        apply_stimulus(-20, 1, 0);
        apply_stimulus(30, 1, 0);
        psum_valid = 1'b1;
        psum = 18'sd77;
        #1;
        check_output("ready_low", 32'(psum_ready), 32'sd0);
        psum_valid = 1'b0;
        repeat (3) @(negedge clk);
        ready_mode = 0;
        apply_stimulus(-40, 1, 0);
        apply_stimulus(50, 1, 0);
        wait_drain();

        // Reset mid-group discards the partial sum.
        apply_stimulus(10, 3, 0);
        apply_stimulus(20, 3, 0);
        do_reset();
        @(negedge clk);
        apply_stimulus(1, 3, 0);
        apply_stimulus(2, 3, 0);
        apply_stimulus(3, 3, 0);
        wait_drain();

        // Random traffic: groups and shift change every beat, downstream ready toggles.
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            int g;
            int s;
            int p;
            g = $urandom_range(0, 4);
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 12);
            p = int'($urandom_range(0, 262143)) - 131072;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            apply_stimulus(p, g, s);
        end
        wait_drain();

        check_output("idle", 32'(dout_valid), 32'sd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
